// File: rtl/data_split_if.sv
// Stream bundle around data_split: byte-wide payload in, packed sample words out, error status.
// "master" is the upstream/test side that drives the byte stream; "slave" is the splitter itself.
interface data_split_if #(
    parameter int BW    = 18,
    parameter int N_PRL = 4,
    parameter int BW_in = 8
);
    logic [BW_in-1:0]          s_data;
    logic                      s_valid;
    logic                      s_last;
    logic                      s_ready;
    logic [N_PRL-1:0][BW-1:0]  m_data;
    logic                      m_valid;
    logic                      m_last;
    logic                      m_ready;
    logic                      frame_err;
    logic [15:0]               err_cnt;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, frame_err, err_cnt
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, frame_err, err_cnt
    );
endinterface

// File: rtl/data_split.sv
// Receive-side byte-to-sample reassembler: packs NBYTES payload bytes (LSB first) into one
// word of N_PRL BW-bit samples and flags payloads that end off a word boundary.
module data_split #(
    parameter int BW       = 18,
    parameter int N_PRL    = 4,
    parameter int BW_in    = 8,
    parameter bit SYNC_RST = 1'b1
) (
    input  logic        clk,
    input  logic        srst_n,
    data_split_if.slave bus
);
    localparam int WORD_W = BW * N_PRL;
    localparam int NBYTES = WORD_W / BW_in;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NBYTES - 1);

    generate
        if (WORD_W % BW_in != 0) begin : g_bad_ratio
            $error("data_split: BW*N_PRL must be a multiple of BW_in");
        end
        if (NBYTES < 2) begin : g_too_narrow
            $error("data_split: a word must span at least two input beats");
        end
    endgenerate

    typedef enum logic {SYNC, COLLECT} state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            byte_cnt;
    logic [(NBYTES-1)*BW_in-1:0] shreg;
    logic [N_PRL-1:0][BW-1:0]    m_data_q;
    logic                        m_valid_q;
    logic                        m_last_q;
    logic                        frame_err_q;
    logic [15:0]                 err_cnt_q;

    logic s_ready;
    logic accept;
    logic word_done;
    logic short_frame;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b1;
        word_done   = 1'b0;
        short_frame = 1'b0;
        // Only the word-completing byte has to wait for a free output register.
        if (state == COLLECT && byte_cnt == LAST_SLOT && m_valid_q && !bus.m_ready)
            s_ready = 1'b0;
        accept = bus.s_valid && s_ready;
        case (state)
            SYNC: begin
                if (accept && bus.s_last) state_nxt = COLLECT;
            end
            COLLECT: begin
                word_done   = accept && (byte_cnt == LAST_SLOT);
                short_frame = accept && bus.s_last && (byte_cnt != LAST_SLOT);
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) state <= SYNC_RST ? SYNC : COLLECT;
        else         state <= state_nxt;
    end

    // NOTE: the byte shift register is reset along with the control state, so a dropped partial word leaves no residue.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            byte_cnt    <= '0;
            shreg       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            frame_err_q <= short_frame;
            if (short_frame && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;

            if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;

            if (state == COLLECT && accept) begin
                if (word_done) begin
                    m_data_q  <= {bus.s_data, shreg};
                    m_last_q  <= bus.s_last;
                    m_valid_q <= 1'b1;
                    byte_cnt  <= '0;
                end else begin
                    for (int k = 0; k < NBYTES - 1; k++)
                        if (byte_cnt == CNT_W'(k)) shreg[BW_in*k +: BW_in] <= bus.s_data;
                    // A payload that ends mid-word restarts at slot 0; stale bytes get overwritten.
                    byte_cnt <= bus.s_last ? '0 : byte_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_data    = m_data_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_last    = m_last_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_data_split.sv
// Directed bench for data_split: one DUT starting in COLLECT, one starting in SYNC.
// Inputs change just after the falling edge; outputs are sampled away from the rising edge.
module tb_data_split;
    localparam int BW    = 18;
    localparam int N_PRL = 4;
    localparam int BW_IN = 8;

    typedef logic [72:0] rx_t;

    logic clk = 1'b0;
    logic srst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   tick_cnt = 0;

    data_split_if #(.BW(BW), .N_PRL(N_PRL), .BW_in(BW_IN)) bus ();
    data_split_if #(.BW(BW), .N_PRL(N_PRL), .BW_in(BW_IN)) bus_s ();

    data_split #(.BW(BW), .N_PRL(N_PRL), .BW_in(BW_IN), .SYNC_RST(1'b0)) dut (
        .clk(clk), .srst_n(srst_n), .bus(bus)
    );
    data_split #(.BW(BW), .N_PRL(N_PRL), .BW_in(BW_IN), .SYNC_RST(1'b1)) dut_s (
        .clk(clk), .srst_n(srst_n), .bus(bus_s)
    );

    always #5 clk = ~clk;

    rx_t  rx_q[$];
    rx_t  rx_s_q[$];
    logic acc, acc_s;
    logic rand_mready = 1'b0;
    logic sready_low = 1'b0;
    logic ferr_s_seen = 1'b0;

    // One clock: record handshakes just before the rising edge, return on the falling edge.
    task automatic tick();
        if (rand_mready) bus.m_ready = 1'($urandom_range(0, 1));
        #1;
        acc   = bus.s_valid && bus.s_ready;
        acc_s = bus_s.s_valid && bus_s.s_ready;
        if (bus.s_valid && !bus.s_ready) sready_low = 1'b1;
        if (bus.m_valid && bus.m_ready) rx_q.push_back({bus.m_last, bus.m_data});
        if (bus_s.m_valid && bus_s.m_ready) rx_s_q.push_back({bus_s.m_last, bus_s.m_data});
        if (bus_s.frame_err) ferr_s_seen = 1'b1;
        tick_cnt++;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        logic done;
        done = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            done = acc;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", d);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_byte_s(input logic [7:0] d, input logic last);
        logic done;
        done = 1'b0;
        bus_s.s_valid = 1'b1; bus_s.s_data = d; bus_s.s_last = last;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            done = acc_s;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_s_timeout: byte %h not accepted within 50 cycles", d);
        end
        bus_s.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0; bus.m_ready = 1;
        bus_s.s_valid = 0; bus_s.s_data = 0; bus_s.s_last = 0; bus_s.m_ready = 1;
        #1 srst_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== 72'h0) begin failures++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last: got %b want 0", bus.m_last); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err: got %b want 0", bus.frame_err); end
        checks++; if (bus.err_cnt !== 16'h0) begin failures++; $display("FAIL rst_err_cnt: got %h want 0", bus.err_cnt); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); end
        checks++; if (bus_s.s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready_sync: got %b want 1", bus_s.s_ready); end
        @(negedge clk);
        srst_n = 1'b1;
    endtask

    task automatic test_single_word();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), i == 9);
            if (i == 8) begin
                checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", bus.m_valid); end
            end
        end
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus.m_valid); end
        checks++; if (bus.m_data !== 72'h090807060504030201) begin failures++; $display("FAIL single_data: got %h want 090807060504030201", bus.m_data); end
        checks++; if (bus.m_data[0] !== 18'h30201) begin failures++; $display("FAIL single_sample0: got %h want 30201", bus.m_data[0]); end
        checks++; if (bus.m_last !== 1'b1) begin failures++; $display("FAIL single_last: got %b want 1", bus.m_last); end
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b want 0", bus.m_valid); end
        checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic test_back_to_back();
        int  t0;
        rx_t exp_w;
        bus.m_ready = 1'b1;
        sready_low = 1'b0;
        t0 = tick_cnt;
        for (int i = 1; i <= 90; i++) send_byte(8'(i), i == 90);
        checks++; if (tick_cnt - t0 != 90) begin failures++; $display("FAIL b2b_cycles: got %0d want 90", tick_cnt - t0); end
        tick();
        checks++; if (sready_low !== 1'b0) begin failures++; $display("FAIL b2b_sready_low: got %b want 0", sready_low); end
        checks++; if (rx_q.size() != 10) begin failures++; $display("FAIL b2b_count: got %0d want 10", rx_q.size()); end
        for (int w = 0; w < 10 && w < rx_q.size(); w++) begin
            for (int k = 0; k < 9; k++) exp_w[8*k +: 8] = 8'(9*w + k + 1);
            exp_w[72] = (w == 9);
            checks++; if (rx_q[w] !== exp_w) begin failures++; $display("FAIL b2b_word%0d: got %h want %h", w, rx_q[w], exp_w); end
        end
        rx_q.delete();
    endtask

    task automatic test_stall();
        int t0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h11 + 8'(i), 1'b0);
        t0 = tick_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1'b0);
        checks++; if (tick_cnt - t0 != 8) begin failures++; $display("FAIL stall_accept_cycles: got %0d want 8", tick_cnt - t0); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL stall_sready: got %b want 0", bus.s_ready); end
        bus.s_valid = 1'b1; bus.s_data = 8'h29; bus.s_last = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (acc !== 1'b0) begin failures++; $display("FAIL stall_accept%0d: got %b want 0", n, acc); end
            checks++; if (bus.m_data !== 72'h191817161514131211 || bus.m_valid !== 1'b1)
                begin failures++; $display("FAIL stall_hold%0d: got %h/%b want 191817161514131211/1", n, bus.m_data, bus.m_valid); end
        end
        bus.m_ready = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stall_release_accept: got %b want 1", acc); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== {1'b0, 72'h191817161514131211})
            begin failures++; $display("FAIL stall_word1: got %0d entries want 1 entry of 0191817161514131211", rx_q.size()); end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 72'h292827262524232221 || bus.m_last !== 1'b1)
            begin failures++; $display("FAIL stall_word2_load: got %b/%h/%b want 1/292827262524232221/1", bus.m_valid, bus.m_data, bus.m_last); end
        tick();
        checks++; if (rx_q.size() != 2 || bus.m_valid !== 1'b0)
            begin failures++; $display("FAIL stall_drain: got %0d entries valid %b want 2 entries valid 0", rx_q.size(), bus.m_valid); end
        rx_q.delete();
    endtask

    task automatic test_frame_err();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send_byte(8'h31 + 8'(i), i == 12);
            if (i == 8) begin
                checks++; if (bus.m_data !== 72'h393837363534333231 || bus.m_last !== 1'b0)
                    begin failures++; $display("FAIL ferr_word1: got %h/%b want 393837363534333231/0", bus.m_data, bus.m_last); end
            end
        end
        checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse: got %b want 1", bus.frame_err); end
        checks++; if (bus.err_cnt !== 16'd1) begin failures++; $display("FAIL ferr_cnt: got %0d want 1", bus.err_cnt); end
        tick();
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL ferr_pulse_width: got %b want 0", bus.frame_err); end
        checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL ferr_count: got %0d want 1", rx_q.size()); end
        for (int i = 0; i < 9; i++) send_byte(8'h41 + 8'(i), i == 8);
        checks++; if (bus.m_data !== 72'h494847464544434241 || bus.m_last !== 1'b1 || bus.m_valid !== 1'b1)
            begin failures++; $display("FAIL ferr_realign: got %h/%b want 494847464544434241/1", bus.m_data, bus.m_last); end
        checks++; if (bus.err_cnt !== 16'd1) begin failures++; $display("FAIL ferr_cnt_hold: got %0d want 1", bus.err_cnt); end
        tick();
        rx_q.delete();
    endtask

    task automatic test_sync();
        int t0;
        bus_s.m_ready = 1'b1;
        ferr_s_seen = 1'b0;
        t0 = tick_cnt;
        for (int i = 0; i < 6; i++) send_byte_s(8'h51 + 8'(i), i == 5);
        checks++; if (tick_cnt - t0 != 6) begin failures++; $display("FAIL sync_discard_cycles: got %0d want 6", tick_cnt - t0); end
        for (int i = 0; i < 9; i++) begin
            send_byte_s(8'h61 + 8'(i), i == 8);
            if (i == 7) begin
                checks++; if (bus_s.m_valid !== 1'b0) begin failures++; $display("FAIL sync_early_valid: got %b want 0", bus_s.m_valid); end
            end
        end
        checks++; if (bus_s.m_data !== 72'h696867666564636261 || bus_s.m_last !== 1'b1 || bus_s.m_valid !== 1'b1)
            begin failures++; $display("FAIL sync_word: got %h/%b want 696867666564636261/1", bus_s.m_data, bus_s.m_last); end
        tick();
        checks++; if (rx_s_q.size() != 1) begin failures++; $display("FAIL sync_count: got %0d want 1", rx_s_q.size()); end
        checks++; if (ferr_s_seen !== 1'b0 || bus_s.err_cnt !== 16'd0)
            begin failures++; $display("FAIL sync_no_err: got %b/%0d want 0/0", ferr_s_seen, bus_s.err_cnt); end
    endtask

    task automatic test_reset_midword();
        rx_q.delete();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h71 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h81 + 8'(i), 1'b0);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL midrst_held: got %b want 1", bus.m_valid); end
        #2 srst_n = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0 || bus.m_data !== 72'h0 || bus.m_last !== 1'b0)
            begin failures++; $display("FAIL midrst_outputs: got %b/%h/%b want 0/0/0", bus.m_valid, bus.m_data, bus.m_last); end
        checks++; if (bus.err_cnt !== 16'd0 || bus.frame_err !== 1'b0)
            begin failures++; $display("FAIL midrst_err: got %0d/%b want 0/0", bus.err_cnt, bus.frame_err); end
        @(negedge clk);
        srst_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(8'h91 + 8'(i), i == 8);
        checks++; if (bus.m_data !== 72'h999897969594939291 || bus.m_last !== 1'b1 || bus.m_valid !== 1'b1)
            begin failures++; $display("FAIL midrst_clean_word: got %h/%b want 999897969594939291/1", bus.m_data, bus.m_last); end
        tick();
        checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL midrst_count: got %0d want 1", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic test_random_gaps();
        int   lens[4] = '{18, 27, 11, 9};
        rx_t  exp_q[$];
        rx_t  w;
        logic [7:0] b;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < lens[p]; i++) begin
                b = 8'($urandom_range(0, 255));
                w[8*(i%9) +: 8] = b;
                if (i % 9 == 8) begin
                    w[72] = (i == lens[p] - 1);
                    exp_q.push_back(w);
                end
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                send_byte(b, i == lens[p] - 1);
            end
        end
        rand_mready = 1'b0;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 20 && rx_q.size() < exp_q.size(); n++) tick();
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (bus.err_cnt !== 16'd1) begin failures++; $display("FAIL rand_err_cnt: got %0d want 1", bus.err_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_frame_err();
        test_sync();
        test_reset_midword();
        rand_mready = 1'b1;
        test_random_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
